// File: rtl/eclk_bus_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------------+
// | eclk_bus_sequencer: 6800-style E clock generator with DTACK / VPA-VMA / timeout    |
// | bus-cycle termination FSM.                                        Revision: 1.0     |
// +-----------------------------------------------------------------------------------+
module eclk_bus_sequencer #(
  parameter  int E_PERIOD   = 10,
  parameter  int E_RISE     = 4,
  parameter  int E_FALL     = 8,
  parameter  int VMA_SAMPLE = 2,
  parameter  int TIMEOUT    = 255,
  localparam int PW         = $clog2(E_PERIOD)
) (
  input  logic          CLK7M,
  input  logic          RESET,
  input  logic          AS,
  input  logic          VPA,
  input  logic          DTACK,
  input  logic          CPUSPACE,
  output logic          E,
  output logic          VMA,
  output logic          DSACK,
  output logic          BERR,
  output logic [PW-1:0] EPHASE,
  output logic          BUSY
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT != 0);

  localparam logic [PW-1:0] PH_LAST   = PW'(E_PERIOD - 1);
  localparam logic [PW-1:0] PH_RISE   = PW'(E_RISE);
  localparam logic [PW-1:0] PH_FALL   = PW'(E_FALL);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(VMA_SAMPLE);
  localparam logic [TW-1:0] TMR_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] TMR_MAX   = {TW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DTWAIT  = 3'd1,
    S_VPAWAIT = 3'd2,
    S_VMACYC  = 3'd3,
    S_ACK     = 3'd4,
    S_BUSERR  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ephase_q, ephase_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          e_q, e_d;
  logic          vma_q, vma_d;
  logic          dsack_q, dsack_d;
  logic          berr_q, berr_d;

  always_comb begin
    ephase_d = (ephase_q == PH_LAST) ? '0 : ephase_q + 1'b1;

    e_d = e_q;
    if (ephase_q == PH_RISE) begin
      e_d = 1'b1;
    end else if (ephase_q == PH_FALL) begin
      e_d = 1'b0;
    end

    state_d = state_q;
    timer_d = timer_q;
    vma_d   = vma_q;
    dsack_d = dsack_q;
    berr_d  = berr_q;

    case (state_q)
      S_IDLE: begin
        // CPU-space cycles are terminated by other logic, so they never leave IDLE here
        if (!AS && !CPUSPACE) begin
          state_d = S_DTWAIT;
          timer_d = '0;
        end
      end
      S_DTWAIT: begin
        if (AS) begin
          state_d = S_IDLE;
          vma_d   = 1'b1;
          dsack_d = 1'b1;
          berr_d  = 1'b1;
        end else if (!DTACK) begin
          state_d = S_ACK;
          dsack_d = 1'b0;
        end else if (!VPA) begin
          state_d = S_VPAWAIT;
        end else begin
          if (timer_q != TMR_MAX) begin
            timer_d = timer_q + 1'b1;
          end
          if (TMO_EN && (timer_q == TMR_LAST)) begin
            state_d = S_BUSERR;
            berr_d  = 1'b0;
          end
        end
      end
      S_VPAWAIT: begin
        if (AS) begin
          state_d = S_IDLE;
          vma_d   = 1'b1;
          dsack_d = 1'b1;
          berr_d  = 1'b1;
        end else if (ephase_q == PH_SAMPLE) begin
          state_d = S_VMACYC;
          vma_d   = 1'b0;
        end
      end
      S_VMACYC: begin
        if (AS) begin
          state_d = S_IDLE;
          vma_d   = 1'b1;
          dsack_d = 1'b1;
          berr_d  = 1'b1;
        end else if (ephase_q == PH_FALL) begin
          // acknowledge lands on the same edge that drops E
          state_d = S_ACK;
          dsack_d = 1'b0;
        end
      end
      S_ACK: begin
        if (AS) begin
          state_d = S_IDLE;
          dsack_d = 1'b1;
          vma_d   = 1'b1;
        end
      end
      S_BUSERR: begin
        if (AS) begin
          state_d = S_IDLE;
          berr_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        vma_d   = 1'b1;
        dsack_d = 1'b1;
        berr_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK7M or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      ephase_q <= '0;
      timer_q  <= '0;
      e_q      <= 1'b0;
      vma_q    <= 1'b1;
      dsack_q  <= 1'b1;
      berr_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      ephase_q <= ephase_d;
      timer_q  <= timer_d;
      e_q      <= e_d;
      vma_q    <= vma_d;
      dsack_q  <= dsack_d;
      berr_q   <= berr_d;
    end
  end

  assign E      = e_q;
  assign VMA    = vma_q;
  assign DSACK  = dsack_q;
  assign BERR   = berr_q;
  assign EPHASE = ephase_q;
  assign BUSY   = (state_q != S_IDLE);

endmodule
`default_nettype wire
